// File: rtl/sonic_cb_reader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sonic_cb_reader : circular-buffer read stage, pointer tracking, 2-entry  |
// |                   latency buffer and valid/ready output stream           |
// | Revision        : 1.0                                                    |
// +--------------------------------------------------------------------------+
module sonic_cb_reader #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH:0]   wr_ptr,
  input  logic                  flush,
  output logic [ADDR_WIDTH-1:0] mem_rd_address,
  output logic                  mem_rd_enable,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH:0]   rd_ptr,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  empty,
  output logic                  overrun
);

  localparam logic [ADDR_WIDTH:0] C_DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [ADDR_WIDTH:0]   r_rd_ptr;
  logic                  r_overrun;
  logic                  r_inflight;
  logic [1:0]            r_cnt;
  logic [DATA_WIDTH-1:0] r_head;
  logic [DATA_WIDTH-1:0] r_tail;

  logic [ADDR_WIDTH:0]   w_level;
  logic                  w_empty;
  logic                  w_avail;
  logic                  w_valid;
  logic                  w_pop;
  logic                  w_push;
  logic [2:0]            w_occ;
  logic                  w_issue;

  assign w_level = wr_ptr - r_rd_ptr;
  assign w_empty = (wr_ptr == r_rd_ptr);
  assign w_avail = !w_empty && !r_overrun;
  assign w_valid = (r_cnt != 2'd0);
  assign w_pop   = w_valid && out_ready;
  assign w_push  = r_inflight;

  // Occupancy after this cycle's pop; a pop never exceeds buffered entries.
  assign w_occ   = {1'b0, r_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_issue = w_avail && !flush && (w_occ < 3'd2);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr   <= '0;
      r_overrun  <= 1'b0;
      r_inflight <= 1'b0;
      r_cnt      <= 2'd0;
      r_head     <= '0;
      r_tail     <= '0;
    end else if (flush) begin
      // Clearing the in-flight flag drops the pending return word.
      r_rd_ptr   <= wr_ptr;
      r_overrun  <= 1'b0;
      r_inflight <= 1'b0;
      r_cnt      <= 2'd0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_level > C_DEPTH) begin
        r_overrun <= 1'b1;
      end
      case ({w_pop, w_push})
        2'b11: begin
          if (r_cnt == 2'd2) begin
            r_head <= r_tail;
            r_tail <= mem_rd_data;
          end else begin
            r_head <= mem_rd_data;
          end
        end
        2'b10: begin
          if (r_cnt == 2'd2) begin
            r_head <= r_tail;
          end
          r_cnt <= r_cnt - 2'd1;
        end
        2'b01: begin
          if (r_cnt == 2'd0) begin
            r_head <= mem_rd_data;
          end else begin
            r_tail <= mem_rd_data;
          end
          r_cnt <= r_cnt + 2'd1;
        end
        default: begin
        end
      endcase
    end
  end

  assign mem_rd_address = r_rd_ptr[ADDR_WIDTH-1:0];
  assign mem_rd_enable  = w_issue;
  assign out_data       = r_head;
  assign out_valid      = w_valid;
  assign rd_ptr         = r_rd_ptr;
  assign level          = w_level;
  assign empty          = w_empty;
  assign overrun        = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_sonic_cb_reader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_sonic_cb_reader : directed bench with a registered-read memory model  |
// | Revision           : 1.0                                                 |
// +--------------------------------------------------------------------------+
module tb_sonic_cb_reader;

  localparam int AW = 13;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          out_ready;
  logic [AW:0]   wr_ptr;
  logic [AW-1:0] mem_rd_address;
  logic          mem_rd_enable;
  logic [DW-1:0] mem_rd_data = '0;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic [AW:0]   rd_ptr;
  logic [AW:0]   level;
  logic          empty;
  logic          overrun;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_rd_enable) mem_rd_data <= mem[mem_rd_address];
  end

  sonic_cb_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .wr_ptr(wr_ptr), .flush(flush),
    .mem_rd_address(mem_rd_address), .mem_rd_enable(mem_rd_enable),
    .mem_rd_data(mem_rd_data), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .rd_ptr(rd_ptr), .level(level), .empty(empty),
    .overrun(overrun)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int beats, n, issued, pops;
    logic p_valid, p_ready;
    logic [DW-1:0] p_data;
    logic [AW-1:0] wa [4];
    logic [DW-1:0] wd [4];

    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    for (int i = 0; i < 100; i++) mem[i] = 8'(2 * i);
    mem[8190] = 8'hA0;
    mem[8191] = 8'hA1;
    wa = '{13'd8190, 13'd8191, 13'd0, 13'd1};
    wd = '{8'hA0, 8'hA1, 8'h00, 8'h02};

    // Reset
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0; wr_ptr = '0;
    repeat (3) tick();
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_en", mem_rd_enable, 0);
    check("rst_addr", mem_rd_address, 0);
    check("rst_data", out_data, 0);
    check("rst_rd_ptr", rd_ptr, 0);
    check("rst_empty", empty, 1);
    check("rst_overrun", overrun, 0);

    // Linear stream with first-beat latency
    tick(); rst = 1'b0; out_ready = 1'b1; #1;
    check("idle_empty", empty, 1);
    check("idle_en", mem_rd_enable, 0);
    tick(); wr_ptr = 14'd1; #1;
    check("first_en", mem_rd_enable, 1);
    check("first_addr", mem_rd_address, 0);
    check("first_level", level, 1);
    tick(); wr_ptr = 14'd2; #1;
    check("lat_t1_valid", out_valid, 0);
    tick(); wr_ptr = 14'd3; #1;
    check("lat_t2_valid", out_valid, 1);
    check("lat_t2_data", out_data, 0);
    beats = 1; n = 0;
    while (beats < 100 && n < 400) begin
      tick(); if (wr_ptr < 14'd100) wr_ptr++; #1; n++;
      if (out_valid && out_ready) begin
        check("lin_beat", out_data, 2 * beats);
        beats++;
      end
    end
    check("lin_count", beats, 100);
    repeat (3) tick();
    #1;
    check("lin_rd_ptr", rd_ptr, 100);
    check("lin_empty", empty, 1);
    check("lin_no_extra", out_valid, 0);

    // Backpressure: ready 1 high / 2 low
    tick(); flush = 1'b1; wr_ptr = '0; #1;
    check("flush_no_issue", mem_rd_enable, 0);
    tick(); flush = 1'b0; #1;
    check("bp_rd_ptr0", rd_ptr, 0);
    tick(); wr_ptr = 14'd100; out_ready = 1'b1; #1;
    beats = 0; issued = 0; pops = 0; n = 0;
    p_valid = 1'b0; p_ready = 1'b1; p_data = '0;
    while (beats < 100 && n < 1000) begin
      if (p_valid && !p_ready) begin
        check("bp_stable_valid", out_valid, 1);
        check("bp_stable_data", out_data, p_data);
      end
      issued += int'(mem_rd_enable);
      if (out_valid && out_ready) begin
        check("bp_beat", out_data, 2 * beats);
        beats++;
        pops++;
      end
      check("bp_outstanding", (issued - pops) <= 2, 1);
      p_valid = out_valid; p_ready = out_ready; p_data = out_data;
      tick(); n++; out_ready = (n % 3 == 0); #1;
    end
    check("bp_count", beats, 100);
    out_ready = 1'b1;
    repeat (3) tick();
    #1;
    check("bp_no_dup", out_valid, 0);
    check("bp_rd_ptr", rd_ptr, 100);

    // Wrap-around
    tick(); flush = 1'b1; wr_ptr = 14'd8190; #1;
    tick(); flush = 1'b0; #1;
    check("wrap_rd_ptr0", rd_ptr, 8190);
    tick(); wr_ptr = 14'd8194; #1;
    beats = 0;
    for (int k = 0; k < 8; k++) begin
      if (k <= 4) check("wrap_level", level, 4 - k);
      check("wrap_en", mem_rd_enable, (k < 4) ? 1 : 0);
      if (k < 4) check("wrap_addr", mem_rd_address, wa[k]);
      if (out_valid) begin
        if (beats < 4) check("wrap_data", out_data, wd[beats]);
        beats++;
      end
      tick(); #1;
    end
    check("wrap_beats", beats, 4);
    check("wrap_rd_ptr", rd_ptr, 8194);

    // Flush with one entry buffered and one read in flight
    tick(); out_ready = 1'b0; wr_ptr = 14'd8199; #1;
    check("fl_a_en", mem_rd_enable, 1);
    check("fl_a_addr", mem_rd_address, 2);
    tick(); #1;
    check("fl_b_en", mem_rd_enable, 1);
    check("fl_b_valid", out_valid, 0);
    tick(); flush = 1'b1; #1;
    check("fl_c_valid", out_valid, 1);
    check("fl_c_data", out_data, 4);
    check("fl_c_en", mem_rd_enable, 0);
    tick(); flush = 1'b0; out_ready = 1'b1; #1;
    check("fl_valid_off", out_valid, 0);
    check("fl_rd_ptr", rd_ptr, 8199);
    check("fl_level", level, 0);
    for (int k = 0; k < 3; k++) begin
      tick(); #1;
      check("fl_dropped", out_valid, 0);
    end

    // Overrun
    tick(); flush = 1'b1; wr_ptr = '0; #1;
    tick(); flush = 1'b0; wr_ptr = 14'd8193; #1;
    check("ovr_pre", overrun, 0);
    check("ovr_level", level, 8193);
    tick(); #1;
    check("ovr_set", overrun, 1);
    check("ovr_en", mem_rd_enable, 0);
    for (int k = 0; k < 3; k++) begin
      tick(); #1;
      check("ovr_sticky", overrun, 1);
      check("ovr_hold_en", mem_rd_enable, 0);
    end
    tick(); flush = 1'b1; #1;
    tick(); flush = 1'b0; #1;
    check("ovr_clear", overrun, 0);
    check("ovr_rd_ptr", rd_ptr, 8193);
    check("ovr_empty", empty, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
